tx_uart: RTL and testbench

- Byte-serial UART transmitter: 8 data bits, no parity, 1 stop bit (8N1), LSB first.
- Bit period is runtime-programmable through baud_div.
- Sits between a host byte source (single-cycle start strobe) and the physical TX line.
- Reports frame acceptance (tx_started) and frame completion (tx_done) with single-cycle pulses.

---
 rtl/tx_uart_if.sv | 11 +
 rtl/tx_uart.sv | 84 ++++++++
 tb/tb_tx_uart.sv | 115 +++++++++++
 3 files changed

// File: rtl/tx_uart_if.sv
// tx_uart_if: host-side byte strobe and serial line status of the 8N1 transmitter
interface tx_uart_if;
  logic [15:0] baud_div;
  logic        start_tx;
  logic [7:0]  data_in;
  logic        tx_pin;
  logic        tx_started;
  logic        tx_done;
  modport master (output baud_div, start_tx, data_in, input tx_pin, tx_started, tx_done);
  modport slave  (input baud_div, start_tx, data_in, output tx_pin, tx_started, tx_done);
endinterface

// File: rtl/tx_uart.sv
// tx_uart: 8N1 LSB-first UART transmitter with runtime bit period and registered strobes
module tx_uart (
  input  logic       clk,
  input  logic       rst_n,
  tx_uart_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        pin_q, pin_d, started_q, started_d, done_q, done_d;
  logic        bit_end;
  assign bit_end = cnt_q == 16'd0;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q - 16'd1;
    div_d     = div_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    pin_d     = pin_q;
    started_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        pin_d = 1'b1;
        if (bus.start_tx) begin
          state_d   = START;
          cnt_d     = bus.baud_div;
          div_d     = bus.baud_div;
          shift_d   = bus.data_in;
          idx_d     = 3'd0;
          pin_d     = 1'b0;
          started_d = 1'b1;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        cnt_d   = div_q;
        pin_d   = shift_q[0];
      end
      DATA: if (bit_end) begin
        // line value is registered, so present the next bit one edge ahead
        cnt_d   = div_q;
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
        pin_d   = (idx_q == 3'd7) ? 1'b1 : shift_q[1];
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        pin_d   = 1'b1;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      div_q     <= 16'd0;
      shift_q   <= 8'd0;
      idx_q     <= 3'd0;
      pin_q     <= 1'b1;
      started_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      pin_q     <= pin_d;
      started_q <= started_d;
      done_q    <= done_d;
    end
  end
  assign bus.tx_pin     = pin_q;
  assign bus.tx_started = started_q;
  assign bus.tx_done    = done_q;
endmodule

// File: tb/tb_tx_uart.sv
// tb_tx_uart: table-driven and randomized checks of tx_uart against a bit-period line model
module tb_tx_uart;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  tx_uart_if bus ();
  tx_uart dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    int          inj;
    logic [9:0]  frame;
    int          len;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start_tx = 1'b0;
      chk("idle_pin", bus.tx_pin, 1);
      chk("idle_started", bus.tx_started, 0);
      chk("idle_done", bus.tx_done, 0);
    end
  endtask

  // caller is at a negedge; frame bit k/(div+1) is expected on the line k cycles after acceptance
  task automatic run_frame(input logic [7:0] d, input logic [15:0] div, input logic [9:0] frame,
                           input int len, input int inj);
    int p;
    p = int'(div) + 1;
    bus.start_tx = 1'b1;
    bus.data_in  = d;
    bus.baud_div = div;
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      bus.start_tx = (k == inj);
      bus.data_in  = (k == inj) ? 8'hFF : 8'($urandom);
      bus.baud_div = 16'($urandom);
      chk("pin", bus.tx_pin, (k < len) ? 32'(frame[k / p]) : 1);
      chk("started", bus.tx_started, 32'(k == 0));
      chk("done", bus.tx_done, 32'(k == len));
    end
    bus.start_tx = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [15:0] dv;
    logic [9:0] fr;
    vecs[0] = '{8'hA5, 16'd434, -1, 10'b1101001010, 4350};
    vecs[1] = '{8'h3C, 16'd0,   -1, 10'b1001111000, 10};
    vecs[2] = '{8'h00, 16'd4,   15, 10'b1000000000, 50};
    vecs[3] = '{8'hFF, 16'd1,   -1, 10'b1111111110, 20};
    vecs[4] = '{8'h81, 16'd2,    7, 10'b1100000010, 30};
    vecs[5] = '{8'h5A, 16'd3,    0, 10'b1010110100, 40};
    bus.start_tx = 1'b1;
    bus.data_in  = 8'h55;
    bus.baud_div = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_pin", bus.tx_pin, 1);
    chk("rst_started", bus.tx_started, 0);
    chk("rst_done", bus.tx_done, 0);
    bus.start_tx = 1'b0;
    rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].data, vecs[i].div, vecs[i].frame, vecs[i].len, vecs[i].inj);
      idle(5);
    end
    // start strobed in the tx_done cycle: second frame begins with no idle gap
    run_frame(vecs[3].data, vecs[3].div, vecs[3].frame, vecs[3].len, -1);
    run_frame(vecs[4].data, vecs[4].div, vecs[4].frame, vecs[4].len, -1);
    idle(3);
    // reset during DATA aborts the frame with no tx_done
    bus.start_tx = 1'b1;
    bus.data_in  = 8'hF0;
    bus.baud_div = 16'd3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.start_tx = 1'b0;
      chk("abort_pin", bus.tx_pin, (k < 4) ? 0 : 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rst_pin", bus.tx_pin, 1);
    chk("abort_rst_started", bus.tx_started, 0);
    chk("abort_rst_done", bus.tx_done, 0);
    rst_n = 1'b1;
    idle(60);
    run_frame(8'h5A, 16'd3, 10'b1010110100, 40, -1);
    idle(2);
    // sweep every byte with random short bit periods and random idle gaps
    for (int i = 0; i < 256; i++) begin
      b  = 8'(i);
      dv = 16'($urandom_range(0, 3));
      fr = {1'b1, b, 1'b0};
      run_frame(b, dv, fr, 10 * (int'(dv) + 1), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1);
      idle(int'($urandom_range(1, 100)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
